four_bit_adder: RTL and testbench
=================================

// Module: four_bit_adder
//
// PURPOSE
//  - Unsigned N-bit ripple-carry adder (default 4 bits) with registered sum and carry-out.
//  - Built from a chain of 1-bit full-adder cells.
//  - Leaf arithmetic block; feeds wider datapaths and serves as the adder-chain reference design.
//  - One-cycle registered result gives a clean timing boundary for downstream logic.
//
// PARAMETERS
//  - WIDTH  4  operand/sum width in bits; legal range 1..32.
//
// PORTS
//  - Clocking: one clock; reset is asynchronous and active-low.
//  - clk    in   1      rising-edge clock
//  - rst_n  in   1      asynchronous active-low reset
//  - a      in   WIDTH  operand A, unsigned, bit 0 = LSB
//  - b      in   WIDTH  operand B, unsigned, bit 0 = LSB
//  - s      out  WIDTH  registered sum = (a+b) mod 2^WIDTH
//  - cf     out  1      registered carry-out (bit WIDTH of a+b)
//
// BEHAVIOUR
//  - Combinational core: c[0]=0; for each i, s_i = a_i^b_i^c[i], c[i+1] = a_i&b_i | c[i]&(a_i^b_i).
//  - cf_next = c[WIDTH]; no carry-in port; carry-in is tied to 0.
//  - Result width: WIDTH+1 bits total ({cf,s} == a+b exactly); no saturation, wraps modulo 2^WIDTH.
//  - Latency: exactly 1 clk. Inputs sampled at rising edge k appear on s/cf after edge k; held until the next edge.
//  - Throughput: a new operand pair every cycle; no handshake, no valid/ready, no enable.
//  - Reset: rst_n low asynchronously forces s=0 and cf=0 (and ovf=0 when present), independent of clk.
//  - Outputs stay 0 while rst_n is low.
//  - First edge after rst_n deasserts registers the current a+b.
//  - Reset mid-operation discards the pending result; no recovery cycle is needed.
//  - Boundary cases:
//    - all-ones + 1 -> s=0, cf=1;
//    - all-ones + all-ones -> s=all-ones<<1 (2^WIDTH-2), cf=1;
//    - 0 + 0 -> s=0, cf=0.
//  - X/Z on inputs propagates; no input sanitising is required.
//
// CONFIGURATION
//  - Macro FOUR_BIT_ADDER_OVF_EN:
//    - Defined: adds output port ovf (1 bit, registered, reset 0).
//      ovf = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement signed overflow of a+b, same 1-cycle latency as s.
//    - Undefined: port ovf does not exist; no extra logic.
//
// STRUCTURE
//  - Package adder_pkg:
//    - localparam ADDER_DEFAULT_WIDTH = 4;
//    - typedef for the {cf,s} result struct (logic cf; logic [WIDTH-1:0] s).
//  - Sub-module full_adder_cell (a, b, ci -> s, co):
//    - purely combinational;
//    - instantiated WIDTH times in a generate loop, carry chained LSB to MSB.
//  - Top holds the carry vector c[WIDTH:0], the output register stage and the optional ovf flop.
//
// TESTING
//  - Reset: hold rst_n=0, drive a=4'hF, b=4'h1 -> s=0, cf=0 throughout; release -> next edge s=4'h0, cf=1.
//  - Simple sums: a=4'h3, b=4'h4 -> s=4'h7, cf=0 one cycle later; a=4'h9, b=4'h6 -> s=4'hF, cf=0.
//  - Max carry: a=4'hF, b=4'hF -> s=4'hE, cf=1; a=4'h8, b=4'h8 -> s=4'h0, cf=1.
//  - Exhaustive: all 256 (a,b) pairs back-to-back, one per cycle -> {cf,s} == a+b from the previous cycle, no gaps.
//  - Async reset mid-stream: assert rst_n=0 between edges while a=4'hA, b=4'h7 -> s/cf drop to 0 immediately, before any clk edge.
//  - With FOUR_BIT_ADDER_OVF_EN: a=4'h7, b=4'h1 -> ovf=1, s=4'h8, cf=0; a=4'hF, b=4'h1 -> ovf=0, cf=1.

Source files
------------

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared constants and types for the ripple-carry adder slice.
//   - ADDER_DEFAULT_WIDTH : default operand/sum width of four_bit_adder
//   - ADDER_MAX_WIDTH     : largest supported operand width
//   - adder_result_t      : {cf, s} result record at the default width
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int ADDER_DEFAULT_WIDTH = 4;
   localparam int ADDER_MAX_WIDTH     = 32;

   typedef struct packed {
      logic                           cf;
      logic [ADDER_DEFAULT_WIDTH-1:0] s;
   } adder_result_t;

endpackage : adder_pkg

// File: rtl/full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
//   Purely combinational 1-bit full adder; the repeating unit of the
//   ripple-carry chain in four_bit_adder.
//   Ports:
//     a, b : operand bits
//     ci   : carry in from the next-lower bit
//     s    : sum bit
//     co   : carry out to the next-higher bit
// -----------------------------------------------------------------------------
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;  // propagate

   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule : full_adder_cell

// File: rtl/four_bit_adder.sv
// -----------------------------------------------------------------------------
// four_bit_adder
//   Unsigned WIDTH-bit ripple-carry adder with a registered {cf, s} result.
//   Carry-in is tied to 0; {cf, s} equals a + b exactly, one clock later.
//   Parameters:
//     WIDTH : operand/sum width, 1..32 (default 4)
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset, clears all outputs
//     a, b  : unsigned operands, bit 0 = LSB
//     s     : registered sum, (a + b) mod 2^WIDTH
//     cf    : registered carry-out (bit WIDTH of a + b)
//     ovf   : registered two's-complement overflow of a + b
//             (present only when FOUR_BIT_ADDER_OVF_EN is defined)
//   Configuration macro: FOUR_BIT_ADDER_OVF_EN
// -----------------------------------------------------------------------------
module four_bit_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
`ifdef FOUR_BIT_ADDER_OVF_EN
   output logic             cf,
   output logic             ovf
`else
   output logic             cf
`endif
);

   typedef struct packed {
      logic             cf;
      logic [WIDTH-1:0] s;
   } result_t;

   logic [WIDTH:0]   c;       // c[i] is the carry into bit i
   logic [WIDTH-1:0] sum;
   result_t          result_d;
   result_t          result_q;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum[i]),
         .co (c[i+1])
      );
   end

   assign result_d.cf = c[WIDTH];
   assign result_d.s  = sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
      end else begin
         result_q <= result_d;
      end
   end

   assign s  = result_q.s;
   assign cf = result_q.cf;

`ifdef FOUR_BIT_ADDER_OVF_EN
   logic ovf_d;
   logic ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of it.
   assign ovf_d = c[WIDTH] ^ c[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule : four_bit_adder

// File: tb/tb_four_bit_adder.sv
// -----------------------------------------------------------------------------
// tb_four_bit_adder
//   Directed and exhaustive bench for four_bit_adder (WIDTH = 4).
//   Expected {cf, s} values are queued when operands are driven and compared
//   one clock later. Define FOUR_BIT_ADDER_OVF_EN to also check ovf.
// -----------------------------------------------------------------------------
module tb_four_bit_adder;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] s;
   logic         cf;
`ifdef FOUR_BIT_ADDER_OVF_EN
   logic         ovf;
   logic         ovf_q[$];
`endif

   logic [W:0]   exp_q[$];
   int           n_tests;
   int           n_fail;

   four_bit_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .s     (s),
`ifdef FOUR_BIT_ADDER_OVF_EN
      .cf    (cf),
      .ovf   (ovf)
`else
      .cf    (cf)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drive one operand pair, queue its expected result, compare it after
   // the capturing edge.
   task automatic step(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
      logic [W:0] e;
      logic [W:0] got;
      @(negedge clk);
      a = av;
      b = bv;
      e = {1'b0, av} + {1'b0, bv};
      exp_q.push_back(e);
`ifdef FOUR_BIT_ADDER_OVF_EN
      ovf_q.push_back((av[W-1] == bv[W-1]) && (e[W-1] != av[W-1]));
`endif
      @(posedge clk);
      #1;
      got = {cf, s};
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         check(tag, {27'd0, got}, {27'd0, exp_q.pop_front()});
`ifdef FOUR_BIT_ADDER_OVF_EN
         check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, ovf_q.pop_front()});
`endif
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_s"},  {28'd0, s},  32'd0);
      check({tag, "_cf"}, {31'd0, cf}, 32'd0);
`ifdef FOUR_BIT_ADDER_OVF_EN
      check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      a       = 4'hF;
      b       = 4'h1;

      // Reset held: outputs stay 0 across edges.
      #1;
      check_zero("reset_t0");
      repeat (3) begin
         @(negedge clk);
         check_zero("reset_held");
      end

      // Release: the next edge registers F+1 = {1,0}.
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(5'h10);
`ifdef FOUR_BIT_ADDER_OVF_EN
      ovf_q.push_back(1'b0);
`endif
      @(posedge clk);
      #1;
      check("reset_release", {27'd0, cf, s}, {27'd0, exp_q.pop_front()});
`ifdef FOUR_BIT_ADDER_OVF_EN
      check("reset_release_ovf", {31'd0, ovf}, {31'd0, ovf_q.pop_front()});
`endif

      // Directed sums and boundaries.
      step(4'h3, 4'h4, "simple_3p4");
      step(4'h9, 4'h6, "simple_9p6");
      step(4'hF, 4'hF, "max_FpF");
      step(4'h8, 4'h8, "max_8p8");
      step(4'h0, 4'h0, "zero_0p0");
      step(4'h7, 4'h1, "ovf_7p1");
      step(4'hF, 4'h1, "wrap_Fp1");

      // Exhaustive, one pair per cycle back to back.
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            step(4'(i), 4'(j), "exhaustive");
         end
      end

      // A few random pairs.
      for (int k = 0; k < 20; k++) begin
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");
      end

      // Async reset between edges: A+7 = 0x11 is registered, then reset
      // must clear outputs before any further clock edge.
      step(4'hA, 4'h7, "pre_async");
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      @(posedge clk);
      #1;
      check_zero("async_reset_held");

      // Recovery: first edge after release registers the current inputs.
      @(negedge clk);
      rst_n = 1'b1;
      step(4'h5, 4'h6, "post_reset");
      step(4'hC, 4'h4, "post_reset2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_four_bit_adder
